// File: rtl/mem_pkg.sv
// mem_pkg
// Shared constants and types for the processor memory responder.
//   - Default widths of the weight ROM and the x/result SRAM.
//   - Bit positions of the two processor chip selects.
//   - Encoding of the LOAD/RUN/DUMP control state.
package mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int RAM_AW = 6;

  // Positions inside the processor csb bus; both selects are active-low.
  localparam int CSB_ROM = 1;
  localparam int CSB_RAM = 0;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

endpackage

// File: rtl/sp_mem_array.sv
// sp_mem_array
// Word-addressed storage with one write port and one registered read port,
// matching the one-cycle read latency of the OpenRAM macros.
// Ports:
//   clk    - clock; writes and reads happen on its rising edge
//   rst    - asynchronous active-low reset, clears only the read register
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata holds its value when low
//   raddr  - read address
//   rdata  - registered read data
module sp_mem_array #(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 8,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage itself is never reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: cleared on reset, otherwise holds until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/proc_mem_responder.sv
// proc_mem_responder
// Memory-side responder for the processor: serves weight ROM and x/result
// SRAM with OpenRAM-style csb/web/addr timing, lets a host preload both
// arrays, streams the SRAM back to the host, and owns the processor reset.
// Ports:
//   clk, rst            - clock and asynchronous active-low reset
//   proc_rst            - active-low processor reset, high only in RUN
//   csb, web, addr, din - processor memory request (csb[1] ROM, csb[0] SRAM)
//   dinw, dinx          - ROM / SRAM read data back to the processor
//   ld_valid, ld_ready, ld_sel, ld_addr, ld_data - host load port
//   ld_done             - pulse: loading finished, release the processor
//   dump_start          - pulse: stream the SRAM out
//   dump_valid, dump_ready, dump_data, dump_last - host dump stream
module proc_mem_responder #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int RAM_AW = mem_pkg::RAM_AW
) (
  input  logic              clk,
  input  logic              rst,
  output logic              proc_rst,
  input  logic [1:0]        csb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dinw,
  output logic [DATA_W-1:0] dinx,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  import mem_pkg::*;

  localparam int ROM_DEPTH = 2 ** ADDR_W;
  localparam int RAM_DEPTH = 2 ** RAM_AW;

  state_t state;
  state_t state_next;

  logic [RAM_AW-1:0] dump_ptr;

  logic              rom_we;
  logic              rom_re;
  logic              ram_we;
  logic              ram_re;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rom_rdata;
  logic [DATA_W-1:0] ram_rdata;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next state and array port muxing. ld_done beats dump_start in LOAD.
  // In DUMP the SRAM read port belongs to the dump pointer, and a read is
  // issued in every cycle where no word is currently being offered.
  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    rom_we     = 1'b0;
    rom_re     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = ld_addr[RAM_AW-1:0];
    ram_raddr  = addr[RAM_AW-1:0];
    ram_wdata  = ld_data;
    case (state)
      ST_LOAD: begin
        ld_ready = 1'b1;
        rom_we   = ld_valid && ld_sel;
        ram_we   = ld_valid && !ld_sel;
        if (ld_done) begin
          state_next = ST_RUN;
        end else if (dump_start) begin
          state_next = ST_DUMP;
        end
      end
      ST_RUN: begin
        rom_re    = !csb[CSB_ROM];
        ram_re    = !csb[CSB_RAM] && web;
        ram_we    = !csb[CSB_RAM] && !web;
        ram_waddr = addr[RAM_AW-1:0];
        ram_wdata = din;
        if (dump_start) begin
          state_next = ST_DUMP;
        end
      end
      ST_DUMP: begin
        ram_re    = !dump_valid;
        ram_raddr = dump_ptr;
        if (dump_valid && dump_ready && dump_last) begin
          state_next = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // Processor reset follows the state being entered, so it rises on the
  // edge into RUN and falls on the edge into DUMP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proc_rst <= 1'b0;
    end else begin
      proc_rst <= (state_next == ST_RUN);
    end
  end

  // Dump sequencer: a read cycle raises dump_valid, a handshake drops it
  // and advances the pointer. The pointer wraps to 0 after the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dump_ptr   <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
    end else if (state == ST_DUMP) begin
      if (!dump_valid) begin
        dump_valid <= 1'b1;
        dump_last  <= (dump_ptr == {RAM_AW{1'b1}});
      end else if (dump_ready) begin
        dump_valid <= 1'b0;
        dump_last  <= 1'b0;
        dump_ptr   <= dump_ptr + 1'b1;
      end
    end else begin
      dump_ptr   <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
    end
  end

  sp_mem_array #(
    .DEPTH  (ROM_DEPTH),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .we    (rom_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (rom_re),
    .raddr (addr),
    .rdata (rom_rdata)
  );

  sp_mem_array #(
    .DEPTH  (RAM_DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign dinw      = rom_rdata;
  assign dinx      = ram_rdata;
  assign dump_data = (state == ST_DUMP) ? ram_rdata : '0;

endmodule

// File: tb/tb_proc_mem_responder.sv
// tb_proc_mem_responder
// Directed bench: host loads, a table of processor requests with expected
// read data, then hand-written reset, dump and simultaneous-pulse sequences.
module tb_proc_mem_responder;

  logic       clk;
  logic       rst;
  logic       proc_rst;
  logic [1:0] csb;
  logic       web;
  logic [6:0] addr;
  logic [7:0] din;
  logic [7:0] dinw;
  logic [7:0] dinx;
  logic       ld_valid;
  logic       ld_ready;
  logic       ld_sel;
  logic [6:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_done;
  logic       dump_start;
  logic       dump_valid;
  logic       dump_ready;
  logic [7:0] dump_data;
  logic       dump_last;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] csb;
    logic       web;
    logic [6:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dinw;
    logic [7:0] exp_dinx;
  } vec_t;

  vec_t vecs [14];

  proc_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .proc_rst   (proc_rst),
    .csb        (csb),
    .web        (web),
    .addr       (addr),
    .din        (din),
    .dinw       (dinw),
    .dinx       (dinx),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_sel     (ld_sel),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_done    (ld_done),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_last  (dump_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM preload pattern: (a*7 + 0x13) mod 256.
  function automatic logic [7:0] rom_val(input int a);
    int v;
    v = (a * 7 + 19) % 256;
    return v[7:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one processor request at a falling edge and let one rising edge act on it.
  task automatic apply_stimulus(input logic [1:0] c, input logic w,
                                input logic [6:0] a, input logic [7:0] d);
    csb  = c;
    web  = w;
    addr = a;
    din  = d;
    @(negedge clk);
  endtask

  task automatic load_word(input logic sel, input logic [6:0] a, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = a;
    ld_data  = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_ld_done();
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx;
    int cyc;
    int bad_prst;

    rst        = 1'b0;
    csb        = 2'b11;
    web        = 1'b1;
    addr       = '0;
    din        = '0;
    ld_valid   = 1'b0;
    ld_sel     = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    ld_done    = 1'b0;
    dump_start = 1'b0;
    dump_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_output("reset proc_rst",   proc_rst,   0);
    check_output("reset dinw",       dinw,       0);
    check_output("reset dinx",       dinx,       0);
    check_output("reset ld_ready",   ld_ready,   1);
    check_output("reset dump_valid", dump_valid, 0);
    check_output("reset dump_data",  dump_data,  0);
    check_output("reset dump_last",  dump_last,  0);
    rst = 1'b1;
    @(negedge clk);

    // Preload both arrays.
    for (int i = 0; i < 128; i++) load_word(1'b1, 7'(i), rom_val(i));
    load_word(1'b1, 7'd5, 8'hA5);
    for (int i = 0; i < 64; i++) load_word(1'b0, 7'(i), 8'(i + 64));
    load_word(1'b0, 7'd3, 8'h3C);

    // Final load word together with ld_done and dump_start: ld_done wins.
    ld_valid   = 1'b1;
    ld_sel     = 1'b0;
    ld_addr    = 7'd0;
    ld_data    = 8'h11;
    ld_done    = 1'b1;
    dump_start = 1'b1;
    @(negedge clk);
    ld_valid   = 1'b0;
    ld_done    = 1'b0;
    dump_start = 1'b0;
    check_output("simul proc_rst",   proc_rst,   1);
    check_output("simul ld_ready",   ld_ready,   0);
    check_output("simul dump_valid", dump_valid, 0);
    repeat (2) @(negedge clk);
    check_output("simul dump_valid later", dump_valid, 0);

    vecs[0]  = '{2'b00, 1'b1, 7'd67,  8'h00, rom_val(67),  8'h3C};
    vecs[1]  = '{2'b01, 1'b1, 7'd5,   8'h00, 8'hA5,        8'h3C};
    vecs[2]  = '{2'b10, 1'b0, 7'd9,   8'h7E, 8'hA5,        8'h3C};
    vecs[3]  = '{2'b10, 1'b1, 7'd9,   8'h00, 8'hA5,        8'h7E};
    vecs[4]  = '{2'b01, 1'b0, 7'd9,   8'h99, rom_val(9),   8'h7E};
    vecs[5]  = '{2'b10, 1'b1, 7'd9,   8'h00, rom_val(9),   8'h7E};
    vecs[6]  = '{2'b00, 1'b1, 7'd9,   8'h00, rom_val(9),   8'h7E};
    vecs[7]  = '{2'b11, 1'b0, 7'd10,  8'h55, rom_val(9),   8'h7E};
    vecs[8]  = '{2'b10, 1'b1, 7'd10,  8'h00, rom_val(9),   8'h4A};
    vecs[9]  = '{2'b10, 1'b0, 7'd74,  8'hD2, rom_val(9),   8'h4A};
    vecs[10] = '{2'b10, 1'b1, 7'd10,  8'h00, rom_val(9),   8'hD2};
    vecs[11] = '{2'b10, 1'b1, 7'd0,   8'h00, rom_val(9),   8'h11};
    vecs[12] = '{2'b00, 1'b1, 7'd127, 8'h00, rom_val(127), 8'h7F};
    vecs[13] = '{2'b10, 1'b1, 7'd74,  8'h00, rom_val(127), 8'hD2};

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].csb, vecs[i].web, vecs[i].addr, vecs[i].din);
      check_output($sformatf("vec%0d dinw", i), dinw, vecs[i].exp_dinw);
      check_output($sformatf("vec%0d dinx", i), dinx, vecs[i].exp_dinx);
      check_output($sformatf("vec%0d proc_rst", i), proc_rst, 1);
    end
    csb = 2'b11;
    web = 1'b1;

    // Host load attempts in RUN are refused.
    ld_valid = 1'b1;
    ld_sel   = 1'b0;
    ld_addr  = 7'd20;
    ld_data  = 8'hEE;
    #1;
    check_output("run ld_ready", ld_ready, 0);
    @(negedge clk);
    ld_sel  = 1'b1;
    ld_addr = 7'd5;
    ld_data = 8'h00;
    @(negedge clk);
    ld_valid = 1'b0;
    apply_stimulus(2'b10, 1'b1, 7'd20, 8'h00);
    check_output("run no sram load", dinx, 8'h54);
    apply_stimulus(2'b01, 1'b1, 7'd5, 8'h00);
    check_output("run no rom load", dinw, 8'hA5);
    csb = 2'b11;

    pulse_ld_done();
    check_output("run ld_done ignored", proc_rst, 1);

    // Asynchronous reset in the middle of RUN.
    #2;
    rst = 1'b0;
    #1;
    check_output("midrun proc_rst", proc_rst, 0);
    check_output("midrun dinw",     dinw,     0);
    check_output("midrun dinx",     dinx,     0);
    check_output("midrun ld_ready", ld_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full dump with backpressure.
    for (int i = 0; i < 64; i++) load_word(1'b0, 7'(i), 8'(i));
    pulse_ld_done();
    check_output("pre-dump proc_rst", proc_rst, 1);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    check_output("dump entry proc_rst", proc_rst, 0);

    idx      = 0;
    cyc      = 0;
    bad_prst = 0;
    while (idx < 64 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      dump_ready = cyc[0];
      if (proc_rst !== 1'b0) bad_prst++;
      if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
        check_output($sformatf("dump word %0d data", idx), dump_data, idx);
        check_output($sformatf("dump word %0d last", idx), dump_last, (idx == 63) ? 1 : 0);
        idx++;
      end
    end
    @(negedge clk);
    dump_ready = 1'b0;
    check_output("dump word count",       idx,        64);
    check_output("dump proc_rst held low", bad_prst,  0);
    check_output("post-dump ld_ready",    ld_ready,   1);
    check_output("post-dump dump_valid",  dump_valid, 0);
    check_output("post-dump proc_rst",    proc_rst,   0);

    // Contents survive the dump and the processor can run again.
    pulse_ld_done();
    check_output("rerun proc_rst", proc_rst, 1);
    apply_stimulus(2'b10, 1'b1, 7'd5, 8'h00);
    check_output("rerun sram5", dinx, 8'h05);
    apply_stimulus(2'b10, 1'b1, 7'd63, 8'h00);
    check_output("rerun sram63", dinx, 8'h3F);
    csb = 2'b11;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
